pulse_period_meter: RTL and testbench

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/prescaler_lib.sv | 11 +
 rtl/pulse_period_meter_lib.sv | 31 +++
 rtl/pulse_period_meter_edge_det.sv | 44 ++++
 rtl/pulse_period_meter.sv | 126 ++++++++++++
 tb/tb_pulse_period_meter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prescaler_lib.sv
// Shared limits for the prescaler / timing block family.
`ifndef PRESCALER_LIB_SV
`define PRESCALER_LIB_SV

package prescaler_lib;

    localparam int MAX_COUNTER_WIDTH = 32;

endpackage

`endif

// File: rtl/pulse_period_meter_lib.sv
// FSM state type and parameter range checks for pulse_period_meter.
`ifndef PULSE_PERIOD_METER_LIB_SV
`define PULSE_PERIOD_METER_LIB_SV

package pulse_period_meter_lib;

    import prescaler_lib::MAX_COUNTER_WIDTH;

    localparam int PPM_MIN_WIDTH = 2;
    localparam int PPM_MAX_WIDTH = MAX_COUNTER_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } ppm_state_t;

    function automatic bit width_ok(input int w);
        return (w >= PPM_MIN_WIDTH) && (w <= PPM_MAX_WIDTH);
    endfunction

    // Upper bound is the largest value the period counter can hold.
    function automatic bit min_period_ok(input int w, input int mp);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (mp >= 1) && (longint'(mp) <= lim);
    endfunction

endpackage

`endif

// File: rtl/pulse_period_meter_edge_det.sv
// pulse_edge_det: optional 2-flop synchronizer, then rising-edge detect on tick_in.
// Synchronizer present only when PULSE_PERIOD_METER_SYNC_EN is defined.
`ifndef PULSE_EDGE_DET_SV
`define PULSE_EDGE_DET_SV

module pulse_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic tick_edge
);

    logic tick_s;
    logic prev;

`ifdef PULSE_PERIOD_METER_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= tick_in;
            sync_p1 <= sync_p0;
        end
    end

    assign tick_s = sync_p1;
`else
    assign tick_s = tick_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= tick_s;
    end

    assign tick_edge = tick_s & ~prev;

endmodule

`endif

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between tick_in rising edges; one-entry valid/ready result register.
// Define PULSE_PERIOD_METER_SYNC_EN to synchronize tick_in before edge detection.
`ifndef PULSE_PERIOD_METER_SV
`define PULSE_PERIOD_METER_SV

module pulse_period_meter
    import pulse_period_meter_lib::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int MIN_PERIOD    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     tick_in,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     period_valid,
    input  logic                     period_ready,
    output logic                     ovf,
    output logic                     lost,
    input  logic                     lost_clr
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] MIN_P   = COUNTER_WIDTH'(MIN_PERIOD);

    if (!width_ok(COUNTER_WIDTH) || !min_period_ok(COUNTER_WIDTH, MIN_PERIOD)) begin : g_param_check
        $error("pulse_period_meter: illegal COUNTER_WIDTH=%0d or MIN_PERIOD=%0d",
               COUNTER_WIDTH, MIN_PERIOD);
    end

    function automatic logic is_saturated(input logic [COUNTER_WIDTH-1:0] c);
        return c == CNT_MAX;
    endfunction

    logic                     tick_edge;
    ppm_state_t               state;
    logic [COUNTER_WIDTH-1:0] cnt;

    logic                     res_new;
    logic                     res_ovf;
    logic [COUNTER_WIDTH-1:0] res_val;
    logic                     glitch;
    logic                     lost_set;

    pulse_edge_det u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .tick_edge (tick_edge)
    );

    // A result is produced either by an edge (if long enough) or by counter saturation.
    always_comb begin
        res_new = 1'b0;
        res_ovf = 1'b0;
        res_val = cnt;
        glitch  = 1'b0;
        if (en && state == ST_MEASURE) begin
            if (tick_edge) begin
                if (cnt < MIN_P) glitch  = 1'b1;
                else             res_new = 1'b1;
            end else if (is_saturated(cnt)) begin
                res_new = 1'b1;
                res_ovf = 1'b1;
                res_val = CNT_MAX;
            end
        end
        lost_set = glitch || (res_new && period_valid && !period_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            ovf          <= 1'b0;
            lost         <= 1'b0;
        end else begin
            if (!en) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: state <= ST_ARMED;
                    ST_ARMED: begin
                        if (tick_edge) begin
                            state <= ST_MEASURE;
                            cnt   <= COUNTER_WIDTH'(1);
                        end
                    end
                    ST_MEASURE: begin
                        // Restart on every edge so back-to-back periods have no dead cycle.
                        if (tick_edge) begin
                            cnt <= COUNTER_WIDTH'(1);
                        end else if (is_saturated(cnt)) begin
                            state <= ST_ARMED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + COUNTER_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            if (res_new && (!period_valid || period_ready)) begin
                period       <= res_val;
                ovf          <= res_ovf;
                period_valid <= 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end

            if (lost_set)      lost <= 1'b1;
            else if (lost_clr) lost <= 1'b0;
        end
    end

endmodule

`endif

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with a result scoreboard on the main instance.
module tb_pulse_period_meter;
    import pulse_period_meter_lib::*;

`ifdef PULSE_PERIOD_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        lost_clr = 1'b0;

    logic        tick_in = 1'b0;
    logic        period_ready = 1'b1;
    logic [15:0] period;
    logic        period_valid;
    logic        ovf;
    logic        lost;

    logic        tick_b = 1'b0;
    logic        ready_b = 1'b0;
    logic [3:0]  period_b;
    logic        valid_b;
    logic        ovf_b;
    logic        lost_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int per;
        int ovf;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_period_meter #(.COUNTER_WIDTH(16), .MIN_PERIOD(4)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tick_in      (tick_in),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .ovf          (ovf),
        .lost         (lost),
        .lost_clr     (lost_clr)
    );

    pulse_period_meter #(.COUNTER_WIDTH(4), .MIN_PERIOD(2)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tick_in      (tick_b),
        .period       (period_b),
        .period_valid (valid_b),
        .period_ready (ready_b),
        .ovf          (ovf_b),
        .lost         (lost_b),
        .lost_clr     (lost_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(output int e);
        e = cyc;
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
    endtask

    task automatic expect_a(input int per, input int ov, input int at);
        sb.push_back('{per, ov, at});
    endtask

    task automatic rearm();
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(2);
    endtask

    // Every accepted result on the main instance is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && period_valid && period_ready) begin
            check("sb_expected_present", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("sb_period", 64'(period), 64'(mon_e.per));
                check("sb_ovf", 64'(ovf), 64'(mon_e.ovf));
                if (mon_e.cyc >= 0) check("sb_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, eb;

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_period", 64'(period), 0);
        check("rst_valid", 64'(period_valid), 0);
        check("rst_ovf", 64'(ovf), 0);
        check("rst_lost", 64'(lost), 0);
        check("rst_valid_b", 64'(valid_b), 0);
        check("rst_state_b", 64'(dut_b.state), 64'(ST_IDLE));
        step(1);
        rst_n = 1'b1;
        en = 1'b1;
        step(3);

        // Five ticks 10 cycles apart -> four results of 10.
        period_ready = 1'b1;
        pulse_a(e0);
        step(9);
        for (int i = 0; i < 4; i++) begin
            pulse_a(e1);
            expect_a(10, 0, e1 + LAT);
            step(9);
        end
        step(5);
        check("t1_drained", 64'(sb.size()), 0);
        check("t1_lost", 64'(lost), 0);

        // 4-bit counter saturates after one edge.
        eb = cyc;
        tick_b = 1'b1;
        step(1);
        tick_b = 1'b0;
        step(LAT + 13);
        @(negedge clk);
        check("ovf_not_early", 64'(valid_b), 0);
        step(1);
        check("ovf_valid", 64'(valid_b), 1);
        check("ovf_period", 64'(period_b), 15);
        check("ovf_flag", 64'(ovf_b), 1);
        check("ovf_cycle", 64'(cyc), 64'(eb + LAT + 15));
        step(5);
        check("ovf_state_armed", 64'(dut_b.state), 64'(ST_ARMED));
        check("ovf_held", 64'(valid_b), 1);
        check("ovf_lost_b", 64'(lost_b), 0);

        // Consumer stalled: first result held, later ones dropped.
        rearm();
        period_ready = 1'b0;
        pulse_a(e0);
        step(4);
        pulse_a(e1);
        step(4);
        pulse_a(e2);
        step(LAT + 2);
        check("stall_valid", 64'(period_valid), 1);
        check("stall_period", 64'(period), 5);
        check("stall_ovf", 64'(ovf), 0);
        check("stall_lost", 64'(lost), 1);
        expect_a(5, 0, -1);
        period_ready = 1'b1;
        step(1);
        period_ready = 1'b0;
        step(1);
        check("stall_consumed", 64'(period_valid), 0);
        check("stall_lost_sticky", 64'(lost), 1);
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;
        check("stall_lost_clr", 64'(lost), 0);

        // Handshake in the same cycle a new result arrives.
        rearm();
        period_ready = 1'b0;
        pulse_a(e0);
        step(4);
        pulse_a(e1);
        step(5);
        expect_a(5, 0, -1);
        e2 = cyc;
        tick_in = 1'b1;
        if (LAT == 1) begin
            period_ready = 1'b1;
            step(1);
            tick_in = 1'b0;
            period_ready = 1'b0;
        end else begin
            step(1);
            tick_in = 1'b0;
            step(LAT - 2);
            period_ready = 1'b1;
            step(1);
            period_ready = 1'b0;
        end
        check("swap_valid", 64'(period_valid), 1);
        check("swap_period", 64'(period), 64'(e2 - e1));
        check("swap_no_loss", 64'(lost), 0);
        expect_a(6, 0, -1);
        period_ready = 1'b1;
        step(2);
        check("swap_drained", 64'(sb.size()), 0);

        // Glitch below MIN_PERIOD; set wins over a simultaneous lost_clr.
        rearm();
        pulse_a(e0);
        step(1);
        lost_clr = 1'b1;
        pulse_a(e1);
        if (LAT > 1) step(LAT - 1);
        lost_clr = 1'b0;
        check("glitch_lost_prio", 64'(lost), 1);
        check("glitch_no_result", 64'(period_valid), 0);
        step(e0 + 8 - cyc);
        pulse_a(e2);
        expect_a(6, 0, e2 + LAT);
        step(LAT + 3);
        check("glitch_drained", 64'(sb.size()), 0);
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;

        // Reset mid-count: outputs clear at once, next edge only arms.
        rearm();
        pulse_a(e0);
        step(11);
        pulse_a(e1);
        expect_a(12, 0, e1 + LAT);
        step(6 + LAT - 1);
        rst_n = 1'b0;
        #1;
        check("mrst_period", 64'(period), 0);
        check("mrst_valid", 64'(period_valid), 0);
        check("mrst_ovf", 64'(ovf), 0);
        check("mrst_lost", 64'(lost), 0);
        step(1);
        rst_n = 1'b1;
        step(e1 + 12 - cyc);
        pulse_a(e0);
        step(11);
        pulse_a(e2);
        expect_a(12, 0, e2 + LAT);
        step(LAT + 3);
        check("mrst_drained", 64'(sb.size()), 0);

        step(5);
        check("final_sb_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
